// File: rtl/fill_seq_pkg.sv
// Shared types, default geometry and helpers for the frame fill sequencer.
package fill_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT_SWAP
  } state_e;

  // Default geometry: 640x480 screen tiled with 16x16 blocks.
  localparam int unsigned DEF_BLOCKS_X = 40;
  localparam int unsigned DEF_BLOCKS_Y = 30;
  localparam int unsigned DEF_ADDR_W   = 11;
  localparam int unsigned DEF_PIX_W    = 8;

  // True when (x, y) is the bottom-right block of a bx-by-by grid.
  function automatic logic is_last_block(input int unsigned x, input int unsigned y,
                                         input int unsigned bx, input int unsigned by);
    return (x == bx - 1) && (y == by - 1);
  endfunction

endpackage

// File: rtl/block_scan_counter.sv
// Raster-order block scanner: column, row and running linear address.
// The linear address is a plain incrementing counter, so no y*BLOCKS_X
// multiplier is needed. On the last block the counter holds its value.
module block_scan_counter
  import fill_seq_pkg::*;
#(
  parameter int unsigned BLOCKS_X = DEF_BLOCKS_X,
  parameter int unsigned BLOCKS_Y = DEF_BLOCKS_Y,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [9:0]        x_o,
  output logic [9:0]        y_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam int unsigned X_W = (BLOCKS_X > 1) ? $clog2(BLOCKS_X) : 1;
  localparam int unsigned Y_W = (BLOCKS_Y > 1) ? $clog2(BLOCKS_Y) : 1;

  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic [ADDR_W-1:0] addr_q;

  assign last_o = is_last_block(32'(x_q), 32'(y_q), BLOCKS_X, BLOCKS_Y);

  // Step through blocks in raster order; clear takes priority over advance.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // the sensitivity list carries only the clock edge.
    if (!reset_n || clear_i) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else if (advance_i && !last_o) begin
      if (x_q == X_W'(BLOCKS_X - 1)) begin
        x_q <= '0;
        y_q <= y_q + Y_W'(1);
      end else begin
        x_q <= x_q + X_W'(1);
      end
      addr_q <= addr_q + ADDR_W'(1);
    end
  end

  assign x_o    = 10'(x_q);
  assign y_o    = 10'(y_q);
  assign addr_o = addr_q;

endmodule

// File: rtl/frame_fill_sequencer.sv
// Double-buffered block framebuffer fill controller. Renders one frame of
// pattern-generator output into the back RAM, then swaps buffers on vsync.
module frame_fill_sequencer
  import fill_seq_pkg::*;
#(
  parameter int unsigned BLOCKS_X = DEF_BLOCKS_X,
  parameter int unsigned BLOCKS_Y = DEF_BLOCKS_Y,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned PIX_W    = DEF_PIX_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              vsync_pulse,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic              wr_ready,
  output logic [9:0]        x_coord_of_current_block,
  output logic [9:0]        y_coord_of_current_block,
  output logic              which_ram,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              display_ram_sel,
  output logic              busy,
  output logic              frame_done
);

  state_e state_q;
  logic   pending_q;
  logic   display_sel_q;
  logic   which_ram_q;
  logic   busy_q;
  logic   frame_done_q;

  logic   scan_last;
  logic   write_fire;

  // A write completes only when the request meets a RAM grant.
  assign wr_en      = (state_q == FILL);
  assign write_fire = wr_en && wr_ready;

  // Counters are cleared while idle so every fill starts at block (0, 0),
  // and hold their last value through WAIT_SWAP.
  block_scan_counter #(
    .BLOCKS_X (BLOCKS_X),
    .BLOCKS_Y (BLOCKS_Y),
    .ADDR_W   (ADDR_W)
  ) u_scan (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (state_q == IDLE),
    .advance_i (write_fire),
    .x_o       (x_coord_of_current_block),
    .y_o       (y_coord_of_current_block),
    .addr_o    (wr_addr),
    .last_o    (scan_last)
  );

  // Fill/swap controller with one-deep start queue and buffer toggle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pending_q     <= 1'b0;
      display_sel_q <= 1'b0;
      which_ram_q   <= 1'b1;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start || pending_q) begin
            state_q   <= FILL;
            busy_q    <= 1'b1;
            pending_q <= 1'b0;
          end
        end
        FILL: begin
          if (start) pending_q <= 1'b1;
          if (write_fire && scan_last) state_q <= WAIT_SWAP;
        end
        WAIT_SWAP: begin
          if (start) pending_q <= 1'b1;
          // Swapping only here keeps the displayed buffer stable mid-scan.
          if (vsync_pulse) begin
            display_sel_q <= ~display_sel_q;
            which_ram_q   <= display_sel_q;
            frame_done_q  <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_data         = pixel_in;
  assign which_ram       = which_ram_q;
  assign display_ram_sel = display_sel_q;
  assign busy            = busy_q;
  assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_frame_fill_sequencer.sv
// Self-checking bench for frame_fill_sequencer: vector table, directed
// corner sequences and randomized stalls against a frame-level model.
module tb_frame_fill_sequencer;

  localparam int BX = 40;
  localparam int BY = 30;
  localparam int AW = 11;
  localparam int PW = 8;
  localparam int N  = BX * BY;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start, vsync_pulse, wr_ready;
  logic [PW-1:0] pixel_in, wr_data;
  logic [9:0]    x_coord, y_coord;
  logic          which_ram, wr_en, display_ram_sel, busy, frame_done;
  logic [AW-1:0] wr_addr;

  frame_fill_sequencer #(
    .BLOCKS_X (BX), .BLOCKS_Y (BY), .ADDR_W (AW), .PIX_W (PW)
  ) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .start                    (start),
    .vsync_pulse              (vsync_pulse),
    .pixel_in                 (pixel_in),
    .wr_ready                 (wr_ready),
    .x_coord_of_current_block (x_coord),
    .y_coord_of_current_block (y_coord),
    .which_ram                (which_ram),
    .wr_en                    (wr_en),
    .wr_addr                  (wr_addr),
    .wr_data                  (wr_data),
    .display_ram_sel          (display_ram_sel),
    .busy                     (busy),
    .frame_done               (frame_done)
  );

  // Stand-in pattern generator: pure function of block and buffer select.
  function automatic logic [7:0] pattern(input logic [9:0] x, input logic [9:0] y,
                                         input logic sel);
    logic [9:0] s;
    s = x * 10'd3 + y * 10'd17;
    return s[7:0] ^ (sel ? 8'hC3 : 8'h00);
  endfunction

  assign pixel_in = pattern(x_coord, y_coord, which_ram);

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int frame_writes = 0;
  int first_w  = 0;
  int last_w   = 0;
  int c0       = 0;

  // Frame-level model: phase 0 idle, 1 filling, 2 awaiting vsync;
  // m_n is the index of the block being written (also the address).
  int m_phase = 0;
  int m_n     = 0;
  bit m_pend  = 1'b0;
  bit m_disp  = 1'b0;
  bit m_fd    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic r, input logic s, input logic v, input logic w);
    reset_n     = r;
    start       = s;
    vsync_pulse = v;
    wr_ready    = w;
  endtask

  task automatic model_step();
    if (!reset_n) begin
      m_phase = 0; m_n = 0; m_pend = 1'b0; m_disp = 1'b0; m_fd = 1'b0;
    end else begin
      m_fd = 1'b0;
      case (m_phase)
        0: begin
          m_n = 0;
          if (start || m_pend) begin m_phase = 1; m_pend = 1'b0; end
        end
        1: begin
          if (start) m_pend = 1'b1;
          if (wr_ready) begin
            if (m_n == N - 1) m_phase = 2;
            else m_n++;
          end
        end
        default: begin
          if (start) m_pend = 1'b1;
          if (vsync_pulse) begin m_disp = !m_disp; m_fd = 1'b1; m_phase = 0; end
        end
      endcase
    end
  endtask

  function automatic logic [63:0] exp_regs();
    return {28'd0, 10'(m_n % BX), 10'(m_n / BX), 11'(m_n), (m_phase == 1), !m_disp,
            m_disp, (m_phase != 0), m_fd};
  endfunction

  function automatic logic [63:0] act_regs();
    return {28'd0, x_coord, y_coord, wr_addr, wr_en, which_ram, display_ram_sel, busy,
            frame_done};
  endfunction

  // One clock: check any completing write, advance the model, compare state.
  task automatic tick();
    #1;
    if (reset_n && wr_en && wr_ready) begin
      check("write", {25'd0, wr_addr, x_coord, y_coord, wr_data},
            {25'd0, 11'(m_n), 10'(m_n % BX), 10'(m_n / BX),
             pattern(10'(m_n % BX), 10'(m_n / BX), !m_disp)});
      if (frame_writes == 0) first_w = cyc;
      last_w = cyc;
      frame_writes++;
    end
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check("regs", act_regs(), exp_regs());
  endtask

  typedef struct {
    logic       rst_n, st, vs, rdy;
    logic       exp_wr_en, exp_busy;
    logic [9:0] exp_x;
    logic [10:0] exp_addr;
    logic       exp_disp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 11'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 11'd0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 11'd0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 11'd0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd1, 11'd1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd2, 11'd2, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd2, 11'd2, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 11'd0, 1'b0};

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].rst_n, vecs[i].st, vecs[i].vs, vecs[i].rdy);
      tick();
      check("vec", 64'({wr_en, busy, x_coord, wr_addr, display_ram_sel}),
            64'({vecs[i].exp_wr_en, vecs[i].exp_busy, vecs[i].exp_x, vecs[i].exp_addr,
                 vecs[i].exp_disp}));
    end

    // Full frame with the grant always high, then swap 50 cycles later.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    c0 = cyc; frame_writes = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (N) tick();
    check("a_count", 64'(frame_writes), 64'(N));
    check("a_first", 64'(first_w - c0), 64'(1));
    check("a_last", 64'(last_w - c0), 64'(N));
    check("a_last_block", 64'({x_coord, y_coord, wr_addr}), 64'({10'd39, 10'd29, 11'd1199}));
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (50) tick();
    check("a_wait_busy", 64'({busy, wr_en}), 64'(2'b10));
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("a_swap", 64'({display_ram_sel, which_ram, frame_done, busy}), 64'(4'b1010));
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("a_done_pulse", 64'(frame_done), 64'(0));

    // Random stalls; vsync at fill cycle 600 and on the last write is ignored.
    c0 = cyc; frame_writes = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 6000 && frame_writes < N; i++) begin
      logic rdy, vs;
      rdy = 1'($urandom_range(0, 1));
      vs  = ((cyc - c0) == 600) || (m_phase == 1 && m_n == N - 1 && rdy);
      drive(1'b1, 1'b0, vs, rdy);
      tick();
    end
    check("b_count", 64'(frame_writes), 64'(N));
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (10) tick();
    check("b_no_swap", 64'({display_ram_sel, busy, frame_done}), 64'(3'b110));
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("b_swap", 64'({display_ram_sel, frame_done}), 64'(2'b01));

    // Two starts during a fill queue exactly one more frame.
    c0 = cyc; frame_writes = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    for (int i = 1; i <= N; i++) begin
      drive(1'b1, (i == 100 || i == 300), 1'b0, 1'b1);
      tick();
    end
    check("c_count1", 64'(frame_writes), 64'(N));
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("c_swap", 64'({display_ram_sel, busy, frame_done}), 64'(3'b101));
    frame_writes = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check("c_pending_fill", 64'({busy, which_ram, wr_en}), 64'(3'b101));
    repeat (N) tick();
    check("c_count2", 64'(frame_writes), 64'(N));
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("c_swap2", 64'({display_ram_sel, frame_done}), 64'(2'b01));
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (5) tick();
    check("c_no_third_busy", 64'(busy), 64'(0));
    check("c_no_third_writes", 64'(frame_writes), 64'(N));

    // Start coinciding with the swap: one idle cycle, then refill.
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (N) tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("d_swap_start", 64'({busy, frame_done, display_ram_sel}), 64'(3'b011));
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check("d_refill", 64'({busy, wr_en, which_ram}), 64'(3'b110));

    // Reset held for three cycles mid-fill aborts everything.
    repeat (100) tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    check("e_reset", 64'({busy, wr_en, x_coord, y_coord, wr_addr, display_ram_sel, which_ram}),
          64'({1'b0, 1'b0, 10'd0, 10'd0, 11'd0, 1'b0, 1'b1}));
    frame_writes = 0;
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (20) tick();
    check("e_no_writes", 64'(frame_writes), 64'(0));
    check("e_idle", 64'({busy, display_ram_sel, frame_done}), 64'(3'b000));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
